fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 51 +++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush forces a NOP bubble and wins over load-enable.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_en_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (load_en_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC mux, tracking of the fetch in flight in the
// synchronous-read memory, and the IF/ID register feeding decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [31:0]       imem_data,
    output logic [31:0]       pc,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid
);

    fetch_state_e state_q, state_d;
    logic         inflight_valid;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         ifid_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect discards the fetch in flight; any advancing edge starts a new one.
    always_comb begin
        state_d = state_q;
        if (branch_taken) begin
            state_d = BOOT;
        end else if (!stall) begin
            state_d = RUN;
        end
    end

    always_comb begin
        inflight_valid = (state_q == RUN);
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (!stall) begin
            pc_d          = pc_q + PC_STEP;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // With nothing in flight the memory output is stale, so IF/ID takes a bubble.
    assign ifid_flush = branch_taken || (!stall && !inflight_valid);

    fetch_stage_if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en_i (!stall),
        .flush_i   (ifid_flush),
        .instr_i   (imem_data),
        .pc4_i     (inflight_pc_q + PC_STEP),
        .instr_o   (ifid_instr),
        .pc4_o     (ifid_pc4),
        .valid_o   (ifid_valid)
    );

    assign imem_addr = pc_q[ADDR_W-1:0];
    assign imem_en   = !stall;
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based fetch model checked every cycle,
// plus directed literal checks that pin the model.
module tb_fetch_stage;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    int testsRun;
    int testsFailed;

    logic [31:0] mem [64];

    logic [31:0] mPc;
    logic [31:0] mInstr;
    logic [31:0] mPc4;
    logic        mValid;
    logic [31:0] inFlight [$];

    fetch_stage #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_data     (imem_data),
        .pc            (pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory that holds its output while disabled.
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr[7:2]];
    end

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return mem[addr[7:2]];
    endfunction

    // Model: every advancing edge launches the current PC into the memory; the
    // address launched on the previous advancing edge lands in IF/ID.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mPc = 32'h0;
            inFlight.delete();
            mInstr = 32'h0;
            mPc4 = 32'h0;
            mValid = 1'b0;
        end else if (branch_taken) begin
            mPc = branch_target;
            inFlight.delete();
            mInstr = 32'h0;
            mPc4 = 32'h0;
            mValid = 1'b0;
        end else if (!stall) begin
            if (inFlight.size() > 0) begin
                logic [31:0] a;
                a = inFlight.pop_front();
                mInstr = memWord(a);
                mPc4 = a + 32'd4;
                mValid = 1'b1;
            end else begin
                mInstr = 32'h0;
                mPc4 = 32'h0;
                mValid = 1'b0;
            end
            inFlight.push_back(mPc);
            mPc = mPc + 32'd4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_pc", pc, mPc);
        checkOutput("model_imem_addr", {24'h0, imem_addr}, {24'h0, mPc[7:0]});
        checkOutput("model_imem_en", {31'h0, imem_en}, {31'h0, ~stall});
        checkOutput("model_ifid_instr", ifid_instr, mInstr);
        checkOutput("model_ifid_pc4", ifid_pc4, mPc4);
        checkOutput("model_ifid_valid", {31'h0, ifid_valid}, {31'h0, mValid});
    end

    task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t);
        stall = s;
        branch_taken = b;
        branch_target = t;
        @(posedge clk);
        #2;
    endtask

    task automatic checkIfid(input string name, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
        checkOutput({name, "_instr"}, ifid_instr, instr);
        checkOutput({name, "_pc4"}, ifid_pc4, pc4);
        checkOutput({name, "_valid"}, {31'h0, ifid_valid}, {31'h0, valid});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun = 0;
        testsFailed = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'hE281_1001;
        reset_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;

        #1;
        checkOutput("reset_pc", pc, 32'h0);
        checkIfid("reset_ifid", 32'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("edge1_pc", pc, 32'h4);
        checkIfid("edge1", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("edge2", 32'hE281_1001, 32'h4, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("edge3", 32'hA000_0001, 32'h8, 1'b1);
        checkOutput("edge3_pc", pc, 32'hC);

        stall = 1'b1;
        #1;
        checkOutput("stall_imem_en", {31'h0, imem_en}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_pc", pc, 32'hC);
        checkIfid("stall_hold", 32'hA000_0001, 32'h8, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("stall_release", 32'hA000_0002, 32'hC, 1'b1);
        checkOutput("pre_branch_pc", pc, 32'h10);

        applyStimulus(1'b0, 1'b1, 32'h40);
        checkOutput("branch_pc", pc, 32'h40);
        checkIfid("branch_bubble1", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("branch_bubble2", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("branch_target", 32'hA000_0010, 32'h44, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("freerun_pc4", ifid_pc4, 32'h48 + 32'(k * 4));
        end

        applyStimulus(1'b1, 1'b1, 32'h80);
        checkOutput("branch_stall_pc", pc, 32'h80);
        checkIfid("branch_stall", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("boot_stall_pc", pc, 32'h80);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("boot_release", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("after_boot", 32'hA000_0020, 32'h84, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        checkOutput("wrap_start_pc", pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_pc", pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("wrap_ifid", 32'hA000_003F, 32'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("wrap_next", 32'hE281_1001, 32'h4, 1'b1);

        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", pc, 32'h0);
        checkIfid("async_reset", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("rerun_pc", pc, 32'h4);
        checkIfid("rerun_edge1", 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkIfid("rerun_edge2", 32'hE281_1001, 32'h4, 1'b1);

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
